// File: rtl/control_sequencer.sv
// Fetch/decode/execute microcode sequencer for the 8-bit bus-based Mini-CPU.
// A T0..T4 step counter plus a halt flag decode into per-step bus strobes.
module control_sequencer #(
  parameter int unsigned OPW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           carry_flag,
  input  logic           zero_flag,
  output logic           pc_out,
  output logic           pc_in,
  output logic           pc_inc,
  output logic           mar_in,
  output logic           ram_out,
  output logic           ram_in,
  output logic           ir_in,
  output logic           ir_out,
  output logic           a_in,
  output logic           a_out,
  output logic           b_in,
  output logic           alu_out,
  output logic           alu_sub,
  output logic           fl_in,
  output logic           out_in,
  output logic [2:0]     step,
  output logic           halted
);

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;

  localparam logic [OPW-1:0] OP_LDA = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_SUB = OPW'(3);
  localparam logic [OPW-1:0] OP_STA = OPW'(4);
  localparam logic [OPW-1:0] OP_LDI = OPW'(5);
  localparam logic [OPW-1:0] OP_JMP = OPW'(6);
  localparam logic [OPW-1:0] OP_JC  = OPW'(7);
  localparam logic [OPW-1:0] OP_JZ  = OPW'(8);
  localparam logic [OPW-1:0] OP_OUT = OPW'(14);
  localparam logic [OPW-1:0] OP_HLT = OPW'(15);

  logic [2:0] step_q, step_nxt;
  logic       halt_q, halt_nxt;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_q <= T0;
      halt_q <= 1'b0;
    end else begin
      step_q <= step_nxt;
      halt_q <= halt_nxt;
    end
  end

  assign step   = step_q;
  assign halted = halt_q;

  // Next-step and strobe decode; strobes stay low in reset and while halted
  always_comb begin
    step_nxt = step_q;
    halt_nxt = halt_q;
    pc_out   = 1'b0;
    pc_in    = 1'b0;
    pc_inc   = 1'b0;
    mar_in   = 1'b0;
    ram_out  = 1'b0;
    ram_in   = 1'b0;
    ir_in    = 1'b0;
    ir_out   = 1'b0;
    a_in     = 1'b0;
    a_out    = 1'b0;
    b_in     = 1'b0;
    alu_out  = 1'b0;
    alu_sub  = 1'b0;
    fl_in    = 1'b0;
    out_in   = 1'b0;
    if (halt_q) begin
      step_nxt = T0;
    end else if (reset) begin
      step_nxt = step_q + 3'd1;
      case (step_q)
        T0: begin
          pc_out = 1'b1;
          mar_in = 1'b1;
        end
        T1: begin
          ram_out = 1'b1;
          ir_in   = 1'b1;
          pc_inc  = 1'b1;
        end
        T2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ir_out = 1'b1;
              mar_in = 1'b1;
            end
            OP_LDI: begin
              ir_out   = 1'b1;
              a_in     = 1'b1;
              step_nxt = T0;
            end
            OP_JMP: begin
              ir_out   = 1'b1;
              pc_in    = 1'b1;
              step_nxt = T0;
            end
            OP_JC: begin
              ir_out   = carry_flag;
              pc_in    = carry_flag;
              step_nxt = T0;
            end
            OP_JZ: begin
              ir_out   = zero_flag;
              pc_in    = zero_flag;
              step_nxt = T0;
            end
            OP_OUT: begin
              a_out    = 1'b1;
              out_in   = 1'b1;
              step_nxt = T0;
            end
            OP_HLT: begin
              halt_nxt = 1'b1;
              step_nxt = T0;
            end
            default: step_nxt = T0;
          endcase
        end
        T3: begin
          case (opcode)
            OP_LDA: begin
              ram_out  = 1'b1;
              a_in     = 1'b1;
              step_nxt = T0;
            end
            OP_ADD, OP_SUB: begin
              ram_out = 1'b1;
              b_in    = 1'b1;
            end
            OP_STA: begin
              a_out    = 1'b1;
              ram_in   = 1'b1;
              step_nxt = T0;
            end
            default: step_nxt = T0;
          endcase
        end
        T4: begin
          step_nxt = T0;
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_out = 1'b1;
            a_in    = 1'b1;
            fl_in   = 1'b1;
            alu_sub = (opcode == OP_SUB);
          end
        end
        default: step_nxt = T0;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch/execute strobes, cycle counts,
// flag-conditional jumps, halt and asynchronous reset behaviour.
module tb_control_sequencer;

  logic       clk;
  logic       reset;
  logic [3:0] opcode;
  logic       carry_flag;
  logic       zero_flag;
  logic       pc_out, pc_in, pc_inc, mar_in, ram_out, ram_in, ir_in, ir_out;
  logic       a_in, a_out, b_in, alu_out, alu_sub, fl_in, out_in;
  logic [2:0] step;
  logic       halted;
  logic [14:0] ctrl;

  int total = 0;
  int bad   = 0;

  localparam logic [14:0] C_PC_OUT  = 15'h4000;
  localparam logic [14:0] C_PC_IN   = 15'h2000;
  localparam logic [14:0] C_PC_INC  = 15'h1000;
  localparam logic [14:0] C_MAR_IN  = 15'h0800;
  localparam logic [14:0] C_RAM_OUT = 15'h0400;
  localparam logic [14:0] C_RAM_IN  = 15'h0200;
  localparam logic [14:0] C_IR_IN   = 15'h0100;
  localparam logic [14:0] C_IR_OUT  = 15'h0080;
  localparam logic [14:0] C_A_IN    = 15'h0040;
  localparam logic [14:0] C_A_OUT   = 15'h0020;
  localparam logic [14:0] C_B_IN    = 15'h0010;
  localparam logic [14:0] C_ALU_OUT = 15'h0008;
  localparam logic [14:0] C_ALU_SUB = 15'h0004;
  localparam logic [14:0] C_FL_IN   = 15'h0002;
  localparam logic [14:0] C_OUT_IN  = 15'h0001;

  localparam logic [14:0] W_F0 = C_PC_OUT | C_MAR_IN;
  localparam logic [14:0] W_F1 = C_RAM_OUT | C_IR_IN | C_PC_INC;

  control_sequencer #(.OPW(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .carry_flag(carry_flag), .zero_flag(zero_flag),
    .pc_out(pc_out), .pc_in(pc_in), .pc_inc(pc_inc), .mar_in(mar_in),
    .ram_out(ram_out), .ram_in(ram_in), .ir_in(ir_in), .ir_out(ir_out),
    .a_in(a_in), .a_out(a_out), .b_in(b_in), .alu_out(alu_out),
    .alu_sub(alu_sub), .fl_in(fl_in), .out_in(out_in),
    .step(step), .halted(halted)
  );

  assign ctrl = {pc_out, pc_in, pc_inc, mar_in, ram_out, ram_in, ir_in, ir_out,
                 a_in, a_out, b_in, alu_out, alu_sub, fl_in, out_in};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected strobes for a given opcode/step/flags
  function automatic logic [14:0] exp_word(input logic [3:0] op, input int st,
                                           input logic c, input logic z);
    logic [14:0] w;
    w = '0;
    case (st)
      0: w = W_F0;
      1: w = W_F1;
      2: case (op)
           4'd1, 4'd2, 4'd3, 4'd4: w = C_IR_OUT | C_MAR_IN;
           4'd5:  w = C_IR_OUT | C_A_IN;
           4'd6:  w = C_IR_OUT | C_PC_IN;
           4'd7:  w = c ? (C_IR_OUT | C_PC_IN) : 15'h0;
           4'd8:  w = z ? (C_IR_OUT | C_PC_IN) : 15'h0;
           4'd14: w = C_A_OUT | C_OUT_IN;
           default: w = '0;
         endcase
      3: case (op)
           4'd1:       w = C_RAM_OUT | C_A_IN;
           4'd2, 4'd3: w = C_RAM_OUT | C_B_IN;
           4'd4:       w = C_A_OUT | C_RAM_IN;
           default:    w = '0;
         endcase
      4: case (op)
           4'd2:    w = C_ALU_OUT | C_A_IN | C_FL_IN;
           4'd3:    w = C_ALU_OUT | C_A_IN | C_FL_IN | C_ALU_SUB;
           default: w = '0;
         endcase
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic int exp_cycles(input logic [3:0] op);
    case (op)
      4'd1, 4'd4: return 4;
      4'd2, 4'd3: return 5;
      default:    return 3;
    endcase
  endfunction

  // Run one instruction from T0; opcode is garbage during fetch
  task automatic exec(input logic [3:0] op, input logic c, input logic z, output int cycles);
    string t;
    carry_flag = c;
    zero_flag  = z;
    opcode     = ~op;
    cycles     = 0;
    for (int s = 0; s < exp_cycles(op); s++) begin
      if (s == 2) opcode = op;
      #1;
      t = $sformatf("op%0d_t%0d", op, s);
      chk({t, "_step"}, 32'(step), 32'(s));
      chk({t, "_ctrl"}, 32'(ctrl), 32'(exp_word(op, s, c, z)));
      if (s == 1) opcode = op;
      tick();
      cycles++;
    end
    #1;
    chk($sformatf("op%0d_end_step", op), 32'(step), 32'd0);
  endtask

  // Bus-drive exclusivity on every cycle
  always @(negedge clk) begin
    chk("bus_onehot", 32'($countones({pc_out, ram_out, ir_out, a_out, alu_out}) <= 1), 32'd1);
  end

  initial begin
    int n, sum;
    reset = 1'b0; opcode = 4'd0; carry_flag = 1'b0; zero_flag = 1'b0;
    repeat (2) tick();
    chk("rst_ctrl", 32'(ctrl), 32'd0);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);

    reset = 1'b1;
    #1;
    chk("rel_t0", 32'(ctrl), 32'(W_F0));

    // Abort ADD in T3 with an asynchronous reset
    opcode = 4'd2;
    tick(); tick(); tick();
    chk("add_t3_step", 32'(step), 32'd3);
    chk("add_t3_ctrl", 32'(ctrl), 32'(C_RAM_OUT | C_B_IN));
    reset = 1'b0;
    #1;
    chk("abort_ctrl", 32'(ctrl), 32'd0);
    chk("abort_step", 32'(step), 32'd0);
    tick();
    chk("abort_hold", 32'(ctrl), 32'd0);
    reset = 1'b1;
    #1;
    chk("resume_t0_ctrl", 32'(ctrl), 32'(W_F0));
    chk("resume_t0_step", 32'(step), 32'd0);
    opcode = 4'd0;
    tick();
    chk("resume_t1_ctrl", 32'(ctrl), 32'(W_F1));
    chk("resume_t1_step", 32'(step), 32'd1);
    tick();
    chk("resume_t2_ctrl", 32'(ctrl), 32'd0);
    tick();
    chk("resume_back_t0", 32'(step), 32'd0);

    // ADD / SUB
    exec(4'd2, 1'b0, 1'b0, n); chk("add_cycles", 32'(n), 32'd5);
    exec(4'd3, 1'b0, 1'b0, n); chk("sub_cycles", 32'(n), 32'd5);

    // Conditional jumps
    exec(4'd7, 1'b0, 1'b1, n); chk("jc0_cycles", 32'(n), 32'd3);
    exec(4'd7, 1'b1, 1'b0, n); chk("jc1_cycles", 32'(n), 32'd3);
    exec(4'd8, 1'b1, 1'b0, n);
    exec(4'd8, 1'b0, 1'b1, n);

    // Carry rising during T2 is honoured in the same cycle
    carry_flag = 1'b0; opcode = 4'd7;
    tick(); tick();
    chk("jc_live_before", 32'(ctrl), 32'd0);
    carry_flag = 1'b1;
    #1;
    chk("jc_live_after", 32'(ctrl), 32'(C_IR_OUT | C_PC_IN));
    tick();
    chk("jc_live_end", 32'(step), 32'd0);

    // LDI, OUT, STA back-to-back
    sum = 0;
    exec(4'd5, 1'b0, 1'b0, n); sum += n;
    exec(4'd14, 1'b0, 1'b0, n); sum += n;
    exec(4'd4, 1'b0, 1'b0, n); sum += n;
    chk("b2b_cycles", 32'(sum), 32'd10);

    // Opcode sweep including undefined ones
    for (int op = 0; op < 15; op++) begin
      exec(4'(op), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), n);
      chk($sformatf("sweep%0d_cycles", op), 32'(n), 32'(exp_cycles(4'(op))));
    end

    // Halt
    exec(4'd15, 1'b1, 1'b1, n);
    chk("hlt_cycles", 32'(n), 32'd3);
    chk("hlt_halted", 32'(halted), 32'd1);
    for (int i = 0; i < 20; i++) begin
      opcode = 4'($urandom_range(0, 15));
      tick();
      chk("hlt_ctrl", 32'(ctrl), 32'd0);
      chk("hlt_step", 32'(step), 32'd0);
      chk("hlt_still", 32'(halted), 32'd1);
    end
    reset = 1'b0;
    #1;
    chk("hlt_rst_halted", 32'(halted), 32'd0);
    chk("hlt_rst_ctrl", 32'(ctrl), 32'd0);
    tick();
    reset = 1'b1;
    #1;
    chk("hlt_rel_t0", 32'(ctrl), 32'(W_F0));
    tick();
    chk("hlt_rel_t1", 32'(ctrl), 32'(W_F1));
    chk("hlt_rel_step", 32'(step), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Fetch/decode/execute microcode sequencer for the 8-bit bus-based Mini-CPU.
- Sits directly upstream of every bus register and drives their load, bus-drive and increment strobes: PC, MAR, IR, A, B, OUT, RAM and ALU.
- Takes the opcode from the IR's direct-read output and the flag bits from the flags register.
- Produces one-hot-per-step control words from an internal step counter.

Parameters:
- OPW, 4, opcode width (the upper nibble of the IR).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  OPW  IR upper nibble (IR direct-read).
- carry_flag  in  1  latched carry from the flags register.
- zero_flag  in  1  latched zero from the flags register.
- pc_out  out  1  PC drives the bus.
- pc_in  out  1  PC loads from the bus.
- pc_inc  out  1  PC increments.
- mar_in  out  1  MAR loads from the bus.
- ram_out  out  1  RAM drives the bus.
- ram_in  out  1  RAM writes from the bus.
- ir_in  out  1  IR loads from the bus.
- ir_out  out  1  IR drives its operand nibble onto the bus.
- a_in  out  1  A register loads from the bus.
- a_out  out  1  A register drives the bus.
- b_in  out  1  B register loads from the bus.
- alu_out  out  1  ALU drives the bus.
- alu_sub  out  1  ALU subtracts.
- fl_in  out  1  flags register latches the ALU flags.
- out_in  out  1  output register loads from the bus.
- step  out  3  current T-state, for debug.
- halted  out  1  sequencer is stopped.

Behaviour:
- State:
  - 3-bit step counter, T0..T4.
  - 1-bit halt flag.
  - All control outputs are decoded combinationally from (step, opcode, flags, halt).
- Reset (reset=0, asynchronous):
  - step=T0, halt=0.
  - While reset is low, every control output is forced to 0 and halted=0.
  - Reset asserted mid-instruction aborts that instruction immediately.
  - After reset is released, the first rising edge is spent in T0.
- Fetch, common to all opcodes:
  - T0: pc_out, mar_in.
  - T1: ram_out, ir_in, pc_inc.
  - Opcode is sampled from T2 onward; the value of opcode during T0/T1 is ignored.
- Execute, with the final step per opcode. After an opcode's final step, step returns to T0 on the next edge; no idle steps.
  - 0 NOP: T2 no strobes; final T2.
  - 1 LDA: T2 ir_out+mar_in; T3 ram_out+a_in; final T3.
  - 2 ADD: T2 ir_out+mar_in; T3 ram_out+b_in; T4 alu_out+a_in+fl_in; final T4.
  - 3 SUB: as ADD, with alu_sub also asserted in T4.
  - 4 STA: T2 ir_out+mar_in; T3 a_out+ram_in; final T3.
  - 5 LDI: T2 ir_out+a_in; final T2.
  - 6 JMP: T2 ir_out+pc_in; final T2.
  - 7 JC: T2 ir_out+pc_in only if carry_flag=1, otherwise no strobes; final T2.
  - 8 JZ: as JC, using zero_flag.
  - 14 OUT: T2 a_out+out_in; final T2.
  - 15 HLT: T2 no strobes; on the T2 edge halt is set and step returns to T0.
  - 9–13 (undefined): treated as NOP.
- Halt:
  - While halt=1, all control outputs are 0, halted=1, and step is held at T0.
  - Only reset clears halt.
- Bus-drive invariant:
  - At most one of pc_out, ram_out, ir_out, a_out, alu_out is high in any cycle.
  - A bench assertion checks this every cycle.
- Flags are sampled combinationally in T2; a change in the same cycle is honoured.
- Instruction cycle counts:
  - 3 cycles: NOP, LDI, JMP, JC, JZ, OUT, HLT, undefined.
  - 4 cycles: LDA, STA.
  - 5 cycles: ADD, SUB.

Test Plan:
- Reset low mid-T3 of ADD -> all strobes 0 immediately, step=0. After release: T0 shows pc_out=1, mar_in=1; T1 shows ram_out=1, ir_in=1, pc_inc=1.
- opcode=2 (ADD) -> T2 ir_out+mar_in, T3 ram_out+b_in, T4 alu_out+a_in+fl_in with alu_sub=0, then T0. opcode=3 gives the same sequence with alu_sub=1 in T4 only.
- opcode=7 with carry_flag=0 -> T2 has no strobes and pc_in=0. Repeat with carry_flag=1 -> T2 ir_out=1, pc_in=1. Both cases return to T0 after 3 cycles.
- Back-to-back LDI (5), OUT (14), STA (4) -> 3+3+4=10 cycles. Step sequence is 0,1,2,0,1,2,0,1,2,3.
- opcode=15 -> halted=1 after the T2 edge. Over 20 further cycles all strobes stay 0 and step=0. Reset low clears halted to 0, and fetch resumes after release.
- Sweep opcodes 0–15 -> never more than one bus driver active per cycle. Opcodes 9–13 take exactly 3 cycles with no strobes in T2.
